// File: rtl/contador_seg.sv
// Seconds counter for the digital clock chain: counts 0..MAX_SEG on a
// one-second tick derived from the input clock. On each wrap back to 0 it
// issues a registered, single-cycle minute carry (modifMin).
module contador_seg #(
  parameter int DIV     = 1,
  parameter int MAX_SEG = 59
) (
  input  logic       clock,
  input  logic       reset,
  output logic [5:0] segundos,
  output logic       modifMin
);

  // Prescaler width; a DIV of 1 still gets a 1-bit register that stays at 0.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [5:0]    SEG_LAST   = 6'(MAX_SEG);

  logic [PW-1:0] presc;
  logic          tick;

  // The tick fires on the edge where the prescaler wraps; with DIV = 1 it is always high.
  always_comb begin
    tick = (presc == PRESC_LAST);
  end

  // Prescaler: counts 0..DIV-1 and restarts on each tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Seconds register and carry. Any value at or above the last legal value,
  // including a corrupted one, wraps to 0 and pulses the carry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      segundos <= '0;
      modifMin <= 1'b0;
    end else if (tick) begin
      if (segundos >= SEG_LAST) begin
        segundos <= '0;
        modifMin <= 1'b1;
      end else begin
        segundos <= segundos + 6'd1;
        modifMin <= 1'b0;
      end
    end else begin
      modifMin <= 1'b0;
    end
  end

endmodule

// File: tb/tb_contador_seg.sv
// Bench for contador_seg: two instances (DIV = 1 and DIV = 4) share clock and
// reset. A reference model derives the expected outputs from the number of
// rising edges seen since reset release.
module tb_contador_seg;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] seg1;
  logic       car1;
  logic [5:0] seg4;
  logic       car4;

  int total  = 0;
  int passed = 0;
  int n      = 0;   // rising edges since reset release
  int pulses1;
  int pulses4;

  contador_seg #(.DIV(1), .MAX_SEG(59)) dut1 (
    .clock    (clock),
    .reset    (reset),
    .segundos (seg1),
    .modifMin (car1)
  );

  contador_seg #(.DIV(4), .MAX_SEG(59)) dut4 (
    .clock    (clock),
    .reset    (reset),
    .segundos (seg4),
    .modifMin (car4)
  );

  always #5 clock = ~clock;

  // Reference model: seconds elapsed = edges / div, displayed modulo 60;
  // the carry is high right after an edge that completes a full minute.
  function automatic int exp_seg(int edges, int div);
    return (edges / div) % 60;
  endfunction

  function automatic int exp_car(int edges, int div);
    return (edges > 0 && (edges % div) == 0 && ((edges / div) % 60) == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One rising edge, then compare both instances against the model.
  task automatic step();
    @(posedge clock);
    n++;
    #1;
    check("seg_div1", {2'b00, seg1}, 8'(exp_seg(n, 1)));
    check("car_div1", {7'd0, car1},  8'(exp_car(n, 1)));
    check("seg_div4", {2'b00, seg4}, 8'(exp_seg(n, 4)));
    check("car_div4", {7'd0, car4},  8'(exp_car(n, 4)));
    if (car1 === 1'b1) pulses1++;
    if (car4 === 1'b1) pulses4++;
  endtask

  // Assert reset between edges, confirm the outputs cleared without a clock
  // edge, then release it on a falling edge.
  task automatic do_reset();
    @(negedge clock);
    #($urandom_range(1, 3));
    reset = 1'b1;
    #1;
    check("rst_seg_div1", {2'b00, seg1}, 8'd0);
    check("rst_car_div1", {7'd0, car1},  8'd0);
    check("rst_seg_div4", {2'b00, seg4}, 8'd0);
    check("rst_car_div4", {7'd0, car4},  8'd0);
    @(negedge clock);
    reset = 1'b0;
    n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset from power-up, checked before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("init_seg_div1", {2'b00, seg1}, 8'd0);
    check("init_car_div1", {7'd0, car1},  8'd0);
    check("init_seg_div4", {2'b00, seg4}, 8'd0);
    check("init_car_div4", {7'd0, car4},  8'd0);
    @(negedge clock);
    reset = 1'b0;
    n = 0;

    // Ten edges, then continue to the wrap and one edge beyond.
    repeat (10) step();
    check("ten_edges", {2'b00, seg1}, 8'd10);
    check("div4_after_8", {2'b00, seg4}, 8'd2);
    repeat (49) step();
    check("at_59", {2'b00, seg1}, 8'd59);
    step();
    check("wrap_seg", {2'b00, seg1}, 8'd0);
    check("wrap_car", {7'd0, car1},  8'd1);
    step();
    check("post_wrap_seg", {2'b00, seg1}, 8'd1);
    check("post_wrap_car", {7'd0, car1},  8'd0);

    // 180 edges from reset: three single-cycle carries for DIV = 1.
    do_reset();
    pulses1 = 0;
    pulses4 = 0;
    repeat (180) step();
    check("pulses_180", 8'(pulses1), 8'd3);

    // Reset while sitting at 59: no carry, and counting resumes from 0.
    do_reset();
    repeat (59) step();
    check("hold_59", {2'b00, seg1}, 8'd59);
    do_reset();
    step();
    check("restart_seg", {2'b00, seg1}, 8'd1);
    check("restart_car", {7'd0, car1},  8'd0);

    // DIV = 4 full minute: one carry at edge 240.
    do_reset();
    pulses1 = 0;
    pulses4 = 0;
    repeat (241) step();
    check("div4_pulses", 8'(pulses4), 8'd1);
    check("div4_seg_241", {2'b00, seg4}, 8'd0);

    // Random run lengths interleaved with asynchronous resets.
    repeat (6) begin
      int k;
      k = $urandom_range(1, 130);
      repeat (k) step();
      do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
